// File: rtl/rs_station_param.sv
// Reservation station that feeds one functional unit from the dispatch stage.
// It takes one instruction per cycle and snoops N_CDB result buses to wake
// waiting operands. Each cycle it offers the oldest ready entry under a
// valid/ready handshake.
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   rdy_in                    global enable; all state holds while low
//   flush                     synchronous clear (qualified by rdy_in)
//   in_*                      dispatch request and its fields; in_ready = not full
//   cdb_valid/value/rob_id    per-channel broadcasts, channel k in slice k
//   issue_*                   oldest ready entry and its handshake
//   count                     current occupancy
module rs_station_param #(
  parameter int unsigned ENTRIES   = 8,
  parameter int unsigned ROB_BITS  = 4,
  parameter int unsigned TYPE_BITS = 5,
  parameter int unsigned N_CDB     = 2,
  parameter int unsigned CNT_BITS  = 6
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TYPE_BITS-1:0]         in_type,
  input  logic [31:0]                  in_v1,
  input  logic [31:0]                  in_v2,
  input  logic                         in_q1_busy,
  input  logic                         in_q2_busy,
  input  logic [ROB_BITS-1:0]          in_q1,
  input  logic [ROB_BITS-1:0]          in_q2,
  input  logic [ROB_BITS-1:0]          in_rob_id,
  input  logic [N_CDB-1:0]             cdb_valid,
  input  logic [N_CDB*32-1:0]          cdb_value,
  input  logic [N_CDB*ROB_BITS-1:0]    cdb_rob_id,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [TYPE_BITS-1:0]         issue_type,
  output logic [31:0]                  issue_v1,
  output logic [31:0]                  issue_v2,
  output logic [ROB_BITS-1:0]          issue_rob_id,
  output logic [CNT_BITS-1:0]          count
);

  localparam int unsigned IdxW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef logic [ENTRIES-1:0] vec_t;

  vec_t                 busy_q, busy_d;
  vec_t                 q1_busy_q, q1_busy_d;
  vec_t                 q2_busy_q, q2_busy_d;
  logic [TYPE_BITS-1:0] type_q [ENTRIES];
  logic [TYPE_BITS-1:0] type_d [ENTRIES];
  logic [31:0]          v1_q   [ENTRIES];
  logic [31:0]          v1_d   [ENTRIES];
  logic [31:0]          v2_q   [ENTRIES];
  logic [31:0]          v2_d   [ENTRIES];
  logic [ROB_BITS-1:0]  q1_q   [ENTRIES];
  logic [ROB_BITS-1:0]  q1_d   [ENTRIES];
  logic [ROB_BITS-1:0]  q2_q   [ENTRIES];
  logic [ROB_BITS-1:0]  q2_d   [ENTRIES];
  logic [ROB_BITS-1:0]  rob_q  [ENTRIES];
  logic [ROB_BITS-1:0]  rob_d  [ENTRIES];
  // older_q[i][j] set: entry i was dispatched before entry j. Only rows and
  // columns of live entries are meaningful; stale bits are never consulted
  // because a dead entry is never ready and its row is rewritten on reuse.
  vec_t                 older_q [ENTRIES];
  vec_t                 older_d [ENTRIES];
  logic [CNT_BITS-1:0]  count_q, count_d;

  vec_t                 ready, grant;
  logic [IdxW-1:0]      free_idx;
  logic                 free_found;
  logic                 dispatch_fire, issue_fire;

  // Lowest-numbered valid channel whose tag matches; bit 32 flags a hit.
  function automatic logic [32:0] snoop(input logic [ROB_BITS-1:0]       tag,
                                        input logic [N_CDB-1:0]          valid,
                                        input logic [N_CDB*32-1:0]       value,
                                        input logic [N_CDB*ROB_BITS-1:0] tags);
    logic [32:0] r;
    r = '0;
    for (int k = 0; k < N_CDB; k++) begin
      if (!r[32] && valid[k] && (tags[k*ROB_BITS +: ROB_BITS] == tag)) begin
        r = {1'b1, value[k*32 +: 32]};
      end
    end
    return r;
  endfunction

  // Oldest-ready selection from registered state only.
  always_comb begin
    ready = busy_q & ~q1_busy_q & ~q2_busy_q;
    grant = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (ready[j] && older_q[j][i]) grant[i] = 1'b0;
      end
    end
  end

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_idx   = IdxW'(i);
        free_found = 1'b1;
      end
    end
  end

  // AND-OR mux: with no grant the outputs read zero, so they stay stable
  // while the state is frozen.
  always_comb begin
    issue_valid  = |ready;
    issue_type   = '0;
    issue_v1     = '0;
    issue_v2     = '0;
    issue_rob_id = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      issue_type   = issue_type   | ({TYPE_BITS{grant[i]}} & type_q[i]);
      issue_v1     = issue_v1     | ({32{grant[i]}}        & v1_q[i]);
      issue_v2     = issue_v2     | ({32{grant[i]}}        & v2_q[i]);
      issue_rob_id = issue_rob_id | ({ROB_BITS{grant[i]}}  & rob_q[i]);
    end
  end

  assign in_ready      = (count_q != CNT_BITS'(ENTRIES));
  assign count         = count_q;
  assign dispatch_fire = in_valid & in_ready & rdy_in;
  assign issue_fire    = issue_valid & issue_ready & rdy_in;

  always_comb begin
    logic [32:0] hit;
    hit       = '0;
    busy_d    = busy_q;
    q1_busy_d = q1_busy_q;
    q2_busy_d = q2_busy_q;
    type_d    = type_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    q1_d      = q1_q;
    q2_d      = q2_q;
    rob_d     = rob_q;
    older_d   = older_q;
    count_d   = count_q + CNT_BITS'(dispatch_fire) - CNT_BITS'(issue_fire);

    // Wake-up of stored operands.
    for (int i = 0; i < ENTRIES; i++) begin
      if (busy_q[i] && q1_busy_q[i]) begin
        hit = snoop(q1_q[i], cdb_valid, cdb_value, cdb_rob_id);
        if (hit[32]) begin
          v1_d[i]      = hit[31:0];
          q1_busy_d[i] = 1'b0;
        end
      end
      if (busy_q[i] && q2_busy_q[i]) begin
        hit = snoop(q2_q[i], cdb_valid, cdb_value, cdb_rob_id);
        if (hit[32]) begin
          v2_d[i]      = hit[31:0];
          q2_busy_d[i] = 1'b0;
        end
      end
    end

    if (issue_fire) busy_d = busy_d & ~grant;

    if (dispatch_fire) begin
      busy_d[free_idx] = 1'b1;
      type_d[free_idx] = in_type;
      rob_d[free_idx]  = in_rob_id;
      q1_d[free_idx]   = in_q1;
      q2_d[free_idx]   = in_q2;
      v1_d[free_idx]   = in_v1;
      v2_d[free_idx]   = in_v2;
      q1_busy_d[free_idx] = in_q1_busy;
      q2_busy_d[free_idx] = in_q2_busy;
      if (in_q1_busy) begin
        hit = snoop(in_q1, cdb_valid, cdb_value, cdb_rob_id);
        if (hit[32]) begin
          v1_d[free_idx]      = hit[31:0];
          q1_busy_d[free_idx] = 1'b0;
        end
      end
      if (in_q2_busy) begin
        hit = snoop(in_q2, cdb_valid, cdb_value, cdb_rob_id);
        if (hit[32]) begin
          v2_d[free_idx]      = hit[31:0];
          q2_busy_d[free_idx] = 1'b0;
        end
      end
      // Every other slot is now older than the newcomer.
      for (int j = 0; j < ENTRIES; j++) older_d[j][free_idx] = 1'b1;
      older_d[free_idx] = '0;
    end

    if (flush) begin
      busy_d    = '0;
      q1_busy_d = '0;
      q2_busy_d = '0;
      count_d   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        type_d[i]  = '0;
        v1_d[i]    = '0;
        v2_d[i]    = '0;
        q1_d[i]    = '0;
        q2_d[i]    = '0;
        rob_d[i]   = '0;
        older_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q    <= '0;
      q1_busy_q <= '0;
      q2_busy_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        type_q[i]  <= '0;
        v1_q[i]    <= '0;
        v2_q[i]    <= '0;
        q1_q[i]    <= '0;
        q2_q[i]    <= '0;
        rob_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else if (rdy_in) begin
      busy_q    <= busy_d;
      q1_busy_q <= q1_busy_d;
      q2_busy_q <= q2_busy_d;
      count_q   <= count_d;
      type_q    <= type_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      q1_q      <= q1_d;
      q2_q      <= q2_d;
      rob_q     <= rob_d;
      older_q   <= older_d;
    end
  end

endmodule

// File: tb/tb_rs_station_param.sv
// Self-checking bench for rs_station_param: directed vector table, directed
// full/reset sequences, then random traffic against an in-order list model.
module tb_rs_station_param;

  localparam int ENTRIES   = 8;
  localparam int ROB_BITS  = 4;
  localparam int TYPE_BITS = 5;
  localparam int N_CDB     = 2;
  localparam int CNT_BITS  = 6;

  logic                      clk_in = 1'b0;
  logic                      rst_in = 1'b1;
  logic                      rdy_in, flush, in_valid, in_ready;
  logic [TYPE_BITS-1:0]      in_type;
  logic [31:0]               in_v1, in_v2;
  logic                      in_q1_busy, in_q2_busy;
  logic [ROB_BITS-1:0]       in_q1, in_q2, in_rob_id;
  logic [N_CDB-1:0]          cdb_valid;
  logic [N_CDB*32-1:0]       cdb_value;
  logic [N_CDB*ROB_BITS-1:0] cdb_rob_id;
  logic                      issue_valid, issue_ready;
  logic [TYPE_BITS-1:0]      issue_type;
  logic [31:0]               issue_v1, issue_v2;
  logic [ROB_BITS-1:0]       issue_rob_id;
  logic [CNT_BITS-1:0]       count;

  always #5 clk_in = ~clk_in;

  rs_station_param #(
    .ENTRIES(ENTRIES), .ROB_BITS(ROB_BITS), .TYPE_BITS(TYPE_BITS),
    .N_CDB(N_CDB), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_v1(in_v1), .in_v2(in_v2), .in_q1_busy(in_q1_busy), .in_q2_busy(in_q2_busy),
    .in_q1(in_q1), .in_q2(in_q2), .in_rob_id(in_rob_id),
    .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_rob_id(cdb_rob_id),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_type(issue_type),
    .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_rob_id(issue_rob_id),
    .count(count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush = 1'b0; in_valid = 1'b0; in_type = '0;
    in_v1 = '0; in_v2 = '0; in_q1_busy = 1'b0; in_q2_busy = 1'b0;
    in_q1 = '0; in_q2 = '0; in_rob_id = '0;
    cdb_valid = '0; cdb_value = '0; cdb_rob_id = '0; issue_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // One cycle of stimulus and the outputs expected after its clock edge.
  typedef struct {
    bit rdy, fl, iv;
    logic [4:0] typ; logic [31:0] v1, v2;
    bit b1, b2; logic [3:0] q1, q2, rob;
    logic [1:0] cv; logic [3:0] ct0, ct1; logic [31:0] cd0, cd1;
    bit ir;
    bit e_iv; logic [4:0] e_typ; logic [31:0] e_v1, e_v2; logic [3:0] e_rob;
    logic [5:0] e_cnt; bit e_inr;
  } vec_t;
  vec_t vt [15];

  // Reference model: live entries kept in dispatch order.
  typedef struct {
    logic [4:0] typ; logic [31:0] v1, v2; bit b1, b2; logic [3:0] q1, q2, rob;
  } ent_t;
  ent_t mq [$];

  function automatic bit cdb_hit(input logic [3:0] tag, output logic [31:0] val);
    val = '0;
    for (int k = 0; k < N_CDB; k++) begin
      if (cdb_valid[k] && cdb_rob_id[k*ROB_BITS +: ROB_BITS] == tag) begin
        val = cdb_value[k*32 +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int first_ready();
    foreach (mq[i]) if (!mq[i].b1 && !mq[i].b2) return i;
    return -1;
  endfunction

  task automatic model_step();
    int pick;
    bit acc;
    ent_t e;
    logic [31:0] val;
    if (!rdy_in) return;
    if (flush) begin
      mq.delete();
      return;
    end
    pick = first_ready();
    acc  = in_valid && (mq.size() < ENTRIES);
    if (pick >= 0 && issue_ready) mq.delete(pick);
    foreach (mq[i]) begin
      if (mq[i].b1 && cdb_hit(mq[i].q1, val)) begin mq[i].v1 = val; mq[i].b1 = 0; end
      if (mq[i].b2 && cdb_hit(mq[i].q2, val)) begin mq[i].v2 = val; mq[i].b2 = 0; end
    end
    if (acc) begin
      e.typ = in_type; e.rob = in_rob_id; e.q1 = in_q1; e.q2 = in_q2;
      e.v1 = in_v1; e.v2 = in_v2; e.b1 = in_q1_busy; e.b2 = in_q2_busy;
      if (e.b1 && cdb_hit(in_q1, val)) begin e.v1 = val; e.b1 = 0; end
      if (e.b2 && cdb_hit(in_q2, val)) begin e.v2 = val; e.b2 = 0; end
      mq.push_back(e);
    end
  endtask

  initial begin
    int idx;
    // Basic issue, oldest-first with late wake, bypass with channel priority,
    // wake priority, frozen cycle, flush against a ready entry and a dispatch.
    vt[0]  = '{1,0,1, 3,5,7,         0,0, 0,0,1, 0,0,0,0,0,          1, 1,3,5,7,1,1,1};
    vt[1]  = '{1,0,0, 0,0,0,         0,0, 0,0,0, 0,0,0,0,0,          1, 0,0,0,0,0,0,1};
    vt[2]  = '{1,0,1, 1,0,'h22,      1,0, 9,0,2, 0,0,0,0,0,          1, 0,0,0,0,0,1,1};
    vt[3]  = '{1,0,1, 2,'h33,'h44,   0,0, 0,0,3, 0,0,0,0,0,          1, 1,2,'h33,'h44,3,2,1};
    vt[4]  = '{1,0,0, 0,0,0,         0,0, 0,0,0, 2,0,9,0,'h11,       1, 1,1,'h11,'h22,2,1,1};
    vt[5]  = '{1,0,0, 0,0,0,         0,0, 0,0,0, 0,0,0,0,0,          1, 0,0,0,0,0,0,1};
    vt[6]  = '{1,0,1, 4,'h55,0,      0,1, 0,4,5, 3,4,4,'hAB,'hCD,    1, 1,4,'h55,'hAB,5,1,1};
    vt[7]  = '{1,0,0, 0,0,0,         0,0, 0,0,0, 0,0,0,0,0,          1, 0,0,0,0,0,0,1};
    vt[8]  = '{1,0,1, 6,0,1,         1,0, 7,0,6, 0,0,0,0,0,          1, 0,0,0,0,0,1,1};
    vt[9]  = '{1,0,0, 0,0,0,         0,0, 0,0,0, 3,7,7,'h70,'h71,    0, 1,6,'h70,1,6,1,1};
    vt[10] = '{0,0,1, 9,9,9,         0,0, 0,0,9, 3,6,6,5,5,          1, 1,6,'h70,1,6,1,1};
    vt[11] = '{1,0,0, 0,0,0,         0,0, 0,0,0, 0,0,0,0,0,          1, 0,0,0,0,0,0,1};
    vt[12] = '{1,0,1, 7,'h77,'h78,   0,0, 0,0,7, 0,0,0,0,0,          0, 1,7,'h77,'h78,7,1,1};
    vt[13] = '{1,1,1, 8,'h88,'h89,   0,0, 0,0,8, 0,0,0,0,0,          1, 0,0,0,0,0,0,1};
    vt[14] = '{1,0,0, 0,0,0,         0,0, 0,0,0, 0,0,0,0,0,          1, 0,0,0,0,0,0,1};

    idle();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset.count", count, 0);
    check("reset.issue_valid", issue_valid, 0);
    check("reset.in_ready", in_ready, 1);
    check("reset.issue_v1", issue_v1, 0);
    check("reset.issue_rob_id", issue_rob_id, 0);
    rst_in = 1'b0;

    foreach (vt[i]) begin
      rdy_in = vt[i].rdy; flush = vt[i].fl; in_valid = vt[i].iv; in_type = vt[i].typ;
      in_v1 = vt[i].v1; in_v2 = vt[i].v2; in_q1_busy = vt[i].b1; in_q2_busy = vt[i].b2;
      in_q1 = vt[i].q1; in_q2 = vt[i].q2; in_rob_id = vt[i].rob;
      cdb_valid = vt[i].cv; cdb_rob_id = {vt[i].ct1, vt[i].ct0};
      cdb_value = {vt[i].cd1, vt[i].cd0}; issue_ready = vt[i].ir;
      step();
      check($sformatf("v%0d.issue_valid", i), issue_valid, vt[i].e_iv);
      check($sformatf("v%0d.count", i), count, vt[i].e_cnt);
      check($sformatf("v%0d.in_ready", i), in_ready, vt[i].e_inr);
      if (vt[i].e_iv) begin
        check($sformatf("v%0d.issue_type", i), issue_type, vt[i].e_typ);
        check($sformatf("v%0d.issue_v1", i), issue_v1, vt[i].e_v1);
        check($sformatf("v%0d.issue_v2", i), issue_v2, vt[i].e_v2);
        check($sformatf("v%0d.issue_rob_id", i), issue_rob_id, vt[i].e_rob);
      end
    end

    // Fill under backpressure, reject a ninth, then release.
    idle();
    issue_ready = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      in_valid = 1'b1; in_rob_id = 4'(8 + i); in_v1 = i;
      step();
      check($sformatf("full.count%0d", i), count, i + 1);
    end
    check("full.in_ready", in_ready, 0);
    check("full.issue_rob_id", issue_rob_id, 8);
    in_rob_id = 4'd0;
    step();
    check("full.ninth_count", count, 8);
    check("full.ninth_oldest", issue_rob_id, 8);
    in_valid = 1'b0; issue_ready = 1'b1;
    step();
    check("full.drain_count", count, 7);
    check("full.drain_in_ready", in_ready, 1);
    check("full.next_oldest", issue_rob_id, 9);

    // Asynchronous reset mid-operation, observed before any clock edge.
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0; issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rob_id = 4'(i);
      step();
    end
    in_valid = 1'b0;
    check("arst.pre_count", count, 3);
    #2 rst_in = 1'b1;
    #1;
    check("arst.count", count, 0);
    check("arst.issue_valid", issue_valid, 0);
    check("arst.in_ready", in_ready, 1);
    #2 rst_in = 1'b0;
    step();

    // Random traffic against the list model.
    idle();
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy_in      = ($urandom_range(0, 7) != 0);
      flush       = ($urandom_range(0, 63) == 0);
      in_valid    = 1'($urandom_range(0, 1));
      in_type     = 5'($urandom);
      in_v1       = $urandom;
      in_v2       = $urandom;
      in_q1_busy  = ($urandom_range(0, 2) == 0);
      in_q2_busy  = ($urandom_range(0, 2) == 0);
      in_q1       = 4'($urandom_range(0, 5));
      in_q2       = 4'($urandom_range(0, 5));
      in_rob_id   = 4'($urandom);
      issue_ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < N_CDB; k++) begin
        cdb_valid[k] = ($urandom_range(0, 2) == 0);
        cdb_rob_id[k*ROB_BITS +: ROB_BITS] = 4'($urandom_range(0, 5));
        cdb_value[k*32 +: 32] = $urandom;
      end
      model_step();
      step();
      idx = first_ready();
      check("rnd.count", count, mq.size());
      check("rnd.in_ready", in_ready, (mq.size() < ENTRIES) ? 1 : 0);
      check("rnd.issue_valid", issue_valid, (idx >= 0) ? 1 : 0);
      if (idx >= 0) begin
        check("rnd.issue_type", issue_type, mq[idx].typ);
        check("rnd.issue_v1", issue_v1, mq[idx].v1);
        check("rnd.issue_v2", issue_v2, mq[idx].v2);
        check("rnd.issue_rob_id", issue_rob_id, mq[idx].rob);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_station_param.md
Name: rs_station_param

Overview:
- Parametrised, next-generation reservation station for the out-of-order core.
- Sits between the decoder/dispatch stage and one functional unit (ALU or branch unit).
- Accepts one instruction per cycle and snoops N_CDB common-data-bus channels to wake waiting operands.
- Issues one ready instruction per cycle, oldest first, under a valid/ready handshake with the functional unit.

Parameters:
ENTRIES, 8, number of station slots (power of two, 2..32)
ROB_BITS, 4, ROB tag width
TYPE_BITS, 5, operation-type field width
N_CDB, 2, number of CDB broadcast channels snooped
CNT_BITS, 6, occupancy counter width (must hold ENTRIES)

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  global enable; state frozen when low
flush  in  1  misprediction clear (synchronous, qualified by rdy_in)
in_valid  in  1  dispatch request
in_ready  out  1  station can accept (= count != ENTRIES)
in_type  in  TYPE_BITS  operation type
in_v1  in  32  operand 1 value
in_v2  in  32  operand 2 value (or immediate)
in_q1_busy  in  1  operand 1 waits on a tag
in_q2_busy  in  1  operand 2 waits on a tag
in_q1  in  ROB_BITS  operand 1 producer tag
in_q2  in  ROB_BITS  operand 2 producer tag
in_rob_id  in  ROB_BITS  destination ROB tag
cdb_valid  in  N_CDB  per-channel broadcast valid
cdb_value  in  N_CDB*32  channel k occupies bits [32k+31:32k]
cdb_rob_id  in  N_CDB*ROB_BITS  channel k tag slice
issue_valid  out  1  a ready entry is presented
issue_ready  in  1  functional unit accepts
issue_type  out  TYPE_BITS  selected entry type
issue_v1  out  32  selected operand 1
issue_v2  out  32  selected operand 2
issue_rob_id  out  ROB_BITS  selected entry tag
count  out  CNT_BITS  current occupancy

Behaviour:
- Reset (async) and flush (posedge clk_in with rdy_in=1): all busy bits, q-busy bits, and stored values cleared; count=0; age state cleared. Outputs after reset: issue_valid=0, issue_* = 0, in_ready=1, count=0.
- rdy_in=0: no state changes. in_valid and CDB traffic in that cycle are lost; the upstream holds them.
- Dispatch fires on in_valid & in_ready. The entry is written into the lowest-index free slot, with free status taken from registered busy bits.
- Dispatch bypass: for each operand with in_qX_busy=1 whose tag matches a valid CDB channel in the same cycle, store that channel's value with busy=0. If several channels match, the lowest channel index wins.
- Wake-up: each cycle, every busy entry operand with q-busy=1 that matches a valid CDB tag captures the value and clears q-busy. Same priority rule as dispatch bypass.
- Readiness: an entry is ready when busy=1, q1-busy=0 and q2-busy=0, using registered flags. An entry woken in cycle t is first eligible in cycle t+1.
- Selection is combinational from registered state:
  - pick the ready entry dispatched earliest (age order, not slot index);
  - ties cannot occur;
  - issue_valid=1 iff any entry is ready;
  - issue_* present that entry's fields;
  - when issue_valid=0, issue_* are don't-care but must be stable under rdy_in=0.
- Issue fire = issue_valid & issue_ready & rdy_in. The selected entry is freed at the clock edge and its slot becomes available for dispatch next cycle. If issue_ready=0, the same entry stays presented (outputs stable) unless an older entry becomes ready.
- count(t+1) = count + dispatch_fire − issue_fire.
  - Simultaneous dispatch and issue when full: in_ready=0, so no dispatch. There is no same-cycle slot reuse.
  - Wrap and overflow are impossible by construction.
- Age tracking: an age matrix or per-entry sequence stamp. Stamps must not alias when ENTRIES dispatches occur without frees.
- Flush has priority over dispatch, issue and wake-up in the same cycle.
- Latency:
  - dispatch with ready operands → issue_valid the next cycle;
  - CDB wake → issue_valid the cycle after the broadcast.

Test Plan:
- Reset mid-operation: fill 3 entries, assert rst_in asynchronously → count=0, issue_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
- Dispatch type=3, v1=5, v2=7, no deps, issue_ready=1 → next cycle issue_valid=1, issue_v1=5, issue_v2=7, issue_rob_id=in_rob_id; count returns to 0 one cycle later.
- Oldest-first ordering:
  - dispatch A (rob 2, q1 tag 9), then B (rob 3, ready);
  - B issues first;
  - broadcast tag 9 with value 0x11 on cdb channel 1 → A issues one cycle after broadcast with issue_v1=0x11.
- Dispatch bypass: in_q2_busy=1, in_q2=4 while cdb channel 0 broadcasts tag 4 value 0xAB in the same cycle → entry issues next cycle with v2=0xAB.
- Backpressure and full:
  - hold issue_ready=0 and dispatch 8 ready entries → in_ready=0 and count=8 after the 8th;
  - a 9th in_valid is ignored;
  - raise issue_ready → oldest (first) rob id issues and in_ready=1 the following cycle.
- Flush with an entry ready and in_valid=1 in the same cycle → count=0, no issue fire, new instruction discarded.
